// File: rtl/vx_banked_operands.sv
// Banked GPR operand collector: gathers up to NUM_SRCS source registers
// per instruction from 1R1W banks, serialising reads only on bank conflicts.
module vx_banked_operands #(
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int NUM_WARPS   = 4,
  parameter int NUM_REGS    = 32,
  parameter int NUM_SRCS    = 3,
  parameter int NUM_BANKS   = 4,
  parameter int TAGW        = 64,
  localparam int WIDW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int RIDW = $clog2(NUM_REGS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDW-1:0]                    in_wid,
  input  logic [NUM_SRCS*RIDW-1:0]           in_rs,
  input  logic [TAGW-1:0]                    in_tag,
  input  logic                               wb_valid,
  input  logic [WIDW-1:0]                    wb_wid,
  input  logic [RIDW-1:0]                    wb_rd,
  input  logic [NUM_THREADS-1:0]             wb_tmask,
  input  logic [NUM_THREADS*XLEN-1:0]        wb_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDW-1:0]                    out_wid,
  output logic [TAGW-1:0]                    out_tag,
  output logic [NUM_SRCS*NUM_THREADS*XLEN-1:0] out_rs_data,
  output logic [31:0]                        conflict_cycles
);

  localparam int ROWS = NUM_WARPS * NUM_REGS / NUM_BANKS;
  localparam int RPB  = NUM_REGS / NUM_BANKS;
  localparam int BW   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int ROWW = (ROWS > 1) ? $clog2(ROWS) : 1;

  function automatic logic [BW-1:0] bank_of(
    input logic [WIDW-1:0] w,
    input logic [RIDW-1:0] r
  );
    return BW'((32'(r) + 32'(w)) % NUM_BANKS);
  endfunction

  function automatic logic [ROWW-1:0] row_of(
    input logic [WIDW-1:0] w,
    input logic [RIDW-1:0] r
  );
    return ROWW'(32'(w) * RPB + 32'(r) / NUM_BANKS);
  endfunction

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                state;
  logic [WIDW-1:0]       wid_q;
  logic [RIDW-1:0]       rs_q [NUM_SRCS];
  logic [TAGW-1:0]       tag_q;
  logic [NUM_SRCS-1:0]   pending;
  logic [NUM_SRCS-1:0]   served;
  logic [NUM_SRCS-1:0]   nz;
  logic                  first_q;
  logic [31:0]           conflict_q;
  logic                  in_fire;
  logic [XLEN-1:0]       opnd [NUM_SRCS][NUM_THREADS];
  logic [XLEN-1:0]       gpr  [NUM_BANKS][ROWS][NUM_THREADS];

  logic [BW-1:0]         src_bank [NUM_SRCS];
  logic [ROWW-1:0]       src_row  [NUM_SRCS];
  logic [NUM_BANKS-1:0]  bank_hit;
  logic [RIDW-1:0]       bank_rid [NUM_BANKS];
  logic [ROWW-1:0]       bank_row [NUM_BANKS];
  logic [XLEN-1:0]       bank_rd  [NUM_BANKS][NUM_THREADS];
  logic [BW-1:0]         wb_bank;
  logic [ROWW-1:0]       wb_row;

  assign wb_bank = bank_of(wb_wid, wb_rd);
  assign wb_row  = row_of(wb_wid, wb_rd);

  always_comb begin
    for (int s = 0; s < NUM_SRCS; s++) begin
      nz[s]       = in_rs[s*RIDW +: RIDW] != '0;
      src_bank[s] = bank_of(wid_q, rs_q[s]);
      src_row[s]  = row_of(wid_q, rs_q[s]);
    end
  end

  // Each bank grants its lowest pending source; equal rids ride along.
  always_comb begin
    bank_hit = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_rid[b] = '0;
      bank_row[b] = '0;
      for (int s = 0; s < NUM_SRCS; s++) begin
        if (pending[s] && src_bank[s] == BW'(b) && !bank_hit[b]) begin
          bank_hit[b] = 1'b1;
          bank_rid[b] = rs_q[s];
          bank_row[b] = src_row[s];
        end
      end
    end
    for (int s = 0; s < NUM_SRCS; s++) begin
      served[s] = pending[s] && bank_hit[src_bank[s]]
               && bank_rid[src_bank[s]] == rs_q[s];
    end
  end

  // Same-cycle writeback wins over the stored lane.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int j = 0; j < NUM_THREADS; j++) begin
        bank_rd[b][j] = gpr[b][bank_row[b]][j];
        if (wb_valid && wb_tmask[j] && wb_bank == BW'(b)
            && wb_row == bank_row[b]) begin
          bank_rd[b][j] = wb_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wb_valid) begin
      for (int j = 0; j < NUM_THREADS; j++) begin
        if (wb_tmask[j]) begin
          gpr[wb_bank][wb_row][j] <= wb_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  assign in_ready = !reset
                 && (state == IDLE || (state == DONE && out_ready));
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      first_q    <= 1'b0;
      conflict_q <= '0;
    end else begin
      unique case (state)
        COLLECT: begin
          pending <= pending & ~served;
          first_q <= 1'b0;
          if (!first_q) conflict_q <= conflict_q + 32'd1;
          for (int s = 0; s < NUM_SRCS; s++) begin
            if (served[s]) begin
              for (int j = 0; j < NUM_THREADS; j++) begin
                opnd[s][j] <= bank_rd[src_bank[s]][j];
              end
            end
          end
          if ((pending & ~served) == '0) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: ;
      endcase
      if (in_fire) begin
        wid_q   <= in_wid;
        tag_q   <= in_tag;
        pending <= nz;
        first_q <= 1'b1;
        state   <= (nz != '0) ? COLLECT : DONE;
        for (int s = 0; s < NUM_SRCS; s++) begin
          rs_q[s] <= in_rs[s*RIDW +: RIDW];
          for (int j = 0; j < NUM_THREADS; j++) begin
            opnd[s][j] <= '0;
          end
        end
      end
    end
  end

  assign out_valid       = state == DONE;
  assign out_wid         = wid_q;
  assign out_tag         = tag_q;
  assign conflict_cycles = conflict_q;

  always_comb begin
    out_rs_data = '0;
    for (int s = 0; s < NUM_SRCS; s++) begin
      for (int j = 0; j < NUM_THREADS; j++) begin
        out_rs_data[(s*NUM_THREADS+j)*XLEN +: XLEN] = opnd[s][j];
      end
    end
  end

endmodule

// File: tb/tb_vx_banked_operands.sv
// Directed bench for vx_banked_operands: table of instructions with
// hand-computed latency/conflict plus handwritten multi-cycle sequences.
module tb_vx_banked_operands;

  localparam int NT = 4;
  localparam int XL = 32;
  localparam int NW = 4;
  localparam int NR = 32;
  localparam int NS = 3;
  localparam int DW = NS * NT * XL;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_wid;
  logic [14:0]    in_rs;
  logic [63:0]    in_tag;
  logic           wb_valid;
  logic [1:0]     wb_wid;
  logic [4:0]     wb_rd;
  logic [3:0]     wb_tmask;
  logic [127:0]   wb_data;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     out_wid;
  logic [63:0]    out_tag;
  logic [DW-1:0]  out_rs_data;
  logic [31:0]    conflict_cycles;

  always #5 clk = ~clk;

  vx_banked_operands #(
    .NUM_THREADS(NT), .XLEN(XL), .NUM_WARPS(NW), .NUM_REGS(NR),
    .NUM_SRCS(NS), .NUM_BANKS(4), .TAGW(64)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wid(in_wid), .in_rs(in_rs), .in_tag(in_tag),
    .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd),
    .wb_tmask(wb_tmask), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wid(out_wid), .out_tag(out_tag),
    .out_rs_data(out_rs_data), .conflict_cycles(conflict_cycles)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] ref_gpr [NW][NR][NT];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] pat(int w, int r, int j);
    if (w == 0 && r >= 5 && r <= 7) return 32'((r - 4) * 16 + j);
    return 32'hA000_0000 | 32'(w << 16) | 32'(r << 8) | 32'(j);
  endfunction

  function automatic logic [DW-1:0] exp_data(int w, int r0, int r1, int r2);
    logic [DW-1:0] d;
    int rs[3];
    rs = '{r0, r1, r2};
    d = '0;
    for (int s = 0; s < NS; s++)
      if (rs[s] != 0)
        for (int j = 0; j < NT; j++)
          d[(s*NT+j)*XL +: XL] = ref_gpr[w][rs[s]][j];
    return d;
  endfunction

  task automatic issue(int w, int r0, int r1, int r2, logic [63:0] tag);
    @(negedge clk);
    in_valid = 1'b1;
    in_wid   = 2'(w);
    in_rs    = {5'(r2), 5'(r1), 5'(r0)};
    in_tag   = tag;
  endtask

  task automatic wait_valid(output int lat);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = 99;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    int         wid;
    int         r0, r1, r2;
    logic [63:0] tag;
    int         lat;
    int         dconf;
  } vec_t;

  vec_t vecs[10];
  int   lat;
  int   exp_conf;
  logic seen;
  logic [DW-1:0] e;

  initial begin
    vecs[0] = '{0,  5,  6,  7, 64'h1001, 2, 0};
    vecs[1] = '{0,  5,  9, 13, 64'h1002, 4, 2};
    vecs[2] = '{0,  0,  0,  0, 64'hABCD, 1, 0};
    vecs[3] = '{0,  6,  6,  0, 64'h1004, 2, 0};
    vecs[4] = '{1,  3,  7, 11, 64'h1005, 4, 2};
    vecs[5] = '{2,  1,  5,  2, 64'h1006, 3, 1};
    vecs[6] = '{3,  9,  9,  9, 64'h1007, 2, 0};
    vecs[7] = '{3, 31,  0,  4, 64'h1008, 2, 0};
    vecs[8] = '{2,  2,  6,  6, 64'h1009, 3, 1};
    vecs[9] = '{1,  0,  4,  8, 64'h100A, 3, 1};

    reset = 1'b1; in_valid = 1'b0; in_wid = '0; in_rs = '0; in_tag = '0;
    wb_valid = 1'b0; wb_wid = '0; wb_rd = '0; wb_tmask = '0; wb_data = '0;
    out_ready = 1'b0;
    exp_conf = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_conflict", 64'(conflict_cycles), 64'd0);
    reset = 1'b0;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int w = 0; w < NW; w++) begin
      for (int r = 1; r < NR; r++) begin
        @(negedge clk);
        wb_valid = 1'b1; wb_wid = 2'(w); wb_rd = 5'(r); wb_tmask = 4'hF;
        for (int j = 0; j < NT; j++) begin
          wb_data[j*XL +: XL] = pat(w, r, j);
          ref_gpr[w][r][j] = pat(w, r, j);
        end
      end
    end
    @(negedge clk);
    wb_valid = 1'b0;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].wid, vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].tag);
      #1 chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
      wait_valid(lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_tag", i), out_tag, vecs[i].tag);
      chk($sformatf("v%0d_wid", i), 64'(out_wid), 64'(vecs[i].wid));
      chkw($sformatf("v%0d_data", i), out_rs_data,
           exp_data(vecs[i].wid, vecs[i].r0, vecs[i].r1, vecs[i].r2));
      exp_conf += vecs[i].dconf;
      chk($sformatf("v%0d_conflict", i), 64'(conflict_cycles), 64'(exp_conf));
      consume();
    end

    // Writeback and read of w1 r3 land in the same cycle.
    @(negedge clk);
    wb_valid = 1'b1; wb_wid = 2'd1; wb_rd = 5'd3; wb_tmask = 4'hF;
    wb_data = {4{32'h1111}};
    @(negedge clk);
    wb_valid = 1'b0;
    issue(1, 3, 0, 0, 64'h2001);
    @(negedge clk);
    in_valid = 1'b0;
    wb_valid = 1'b1; wb_wid = 2'd1; wb_rd = 5'd3; wb_tmask = 4'b0101;
    wb_data = {4{32'h0000DEAD}};
    chk("byp_not_yet_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    wb_valid = 1'b0;
    chk("byp_valid", 64'(out_valid), 64'd1);
    e = '0;
    e[127:0] = {32'h1111, 32'hDEAD, 32'h1111, 32'hDEAD};
    chkw("byp_data", out_rs_data, e);
    consume();

    // Output held under backpressure, then back-to-back acceptance.
    issue(0, 5, 6, 7, 64'h3001);
    wait_valid(lat);
    chk("stall_latency", 64'(lat), 64'd2);
    e = exp_data(0, 5, 6, 7);
    for (int k = 0; k < 5; k++) begin
      chkw($sformatf("stall%0d_data", k), out_rs_data, e);
      chk($sformatf("stall%0d_vr", k), {62'd0, out_valid, in_ready},
          64'b10);
      chk($sformatf("stall%0d_tag", k), out_tag, 64'h3001);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_wid = 2'd2; in_rs = '0; in_tag = 64'h55;
    #1 chk("b2b_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_tag", out_tag, 64'h55);
    chk("b2b_wid", 64'(out_wid), 64'd2);
    chkw("b2b_data", out_rs_data, '0);
    consume();

    // Reset in the middle of a three-way conflict.
    chk("pre_rst_conflict", 64'(conflict_cycles), 64'(exp_conf));
    issue(0, 5, 9, 13, 64'h4001);
    @(negedge clk);
    in_valid = 1'b0;
    chk("collect_in_ready", 64'(in_ready), 64'd0);
    chk("collect_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_conflict", 64'(conflict_cycles), 64'd0);
    reset = 1'b0;
    #1 chk("mid_rst_release_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_valid", 64'(seen), 64'd0);
    chk("mid_rst_conflict_after", 64'(conflict_cycles), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
